// File: rtl/axi_perf_wr_mon.sv
// Passive AXI write-channel performance monitor: counts handshakes, stalls and responses
// between a start pulse and the end of the writer's activity, and tracks bursts awaiting B.
module axi_perf_wr_mon #(
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned OUTS_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_busy,
  input  logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  input  logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  input  logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  active,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cycles,
  output logic [CNT_WIDTH-1:0]  aw_bursts,
  output logic [CNT_WIDTH-1:0]  w_beats,
  output logic [CNT_WIDTH-1:0]  w_lasts,
  output logic [CNT_WIDTH-1:0]  aw_stalls,
  output logic [CNT_WIDTH-1:0]  w_stalls,
  output logic [CNT_WIDTH-1:0]  b_resps,
  output logic [CNT_WIDTH-1:0]  b_errors,
  output logic [OUTS_WIDTH-1:0] outstanding,
  output logic [OUTS_WIDTH-1:0] max_outstanding,
  output logic                  proto_err
);

  // A zero-width ID is not a legal configuration; such an instance never arms.
  localparam bit IdCfgOk = (AXI_ID_WIDTH > 0);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]  aw_bursts_q, aw_bursts_d;
  logic [CNT_WIDTH-1:0]  w_beats_q, w_beats_d;
  logic [CNT_WIDTH-1:0]  w_lasts_q, w_lasts_d;
  logic [CNT_WIDTH-1:0]  aw_stalls_q, aw_stalls_d;
  logic [CNT_WIDTH-1:0]  w_stalls_q, w_stalls_d;
  logic [CNT_WIDTH-1:0]  b_resps_q, b_resps_d;
  logic [CNT_WIDTH-1:0]  b_errors_q, b_errors_d;
  logic [OUTS_WIDTH-1:0] outstanding_q, outstanding_d;
  logic [OUTS_WIDTH-1:0] max_outstanding_q, max_outstanding_d;
  logic                  proto_err_q, proto_err_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic               en);
    sat_inc = (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  always_comb begin
    state_d           = state_q;
    seen_busy_d       = seen_busy_q;
    cycles_d          = cycles_q;
    aw_bursts_d       = aw_bursts_q;
    w_beats_d         = w_beats_q;
    w_lasts_d         = w_lasts_q;
    aw_stalls_d       = aw_stalls_q;
    w_stalls_d        = w_stalls_q;
    b_resps_d         = b_resps_q;
    b_errors_d        = b_errors_q;
    outstanding_d     = outstanding_q;
    max_outstanding_d = max_outstanding_q;
    proto_err_d       = proto_err_q;

    case (state_q)
      StIdle: begin
        if (start && IdCfgOk) begin
          seen_busy_d       = 1'b0;
          cycles_d          = '0;
          aw_bursts_d       = '0;
          w_beats_d         = '0;
          w_lasts_d         = '0;
          aw_stalls_d       = '0;
          w_stalls_d        = '0;
          b_resps_d         = '0;
          b_errors_d        = '0;
          outstanding_d     = '0;
          max_outstanding_d = '0;
          proto_err_d       = 1'b0;
          state_d           = StRun;
        end
      end

      StRun, StDrain: begin
        cycles_d    = sat_inc(cycles_q, 1'b1);
        aw_bursts_d = sat_inc(aw_bursts_q, aw_hs);
        w_beats_d   = sat_inc(w_beats_q, w_hs);
        w_lasts_d   = sat_inc(w_lasts_q, w_hs & m_axi_wlast);
        aw_stalls_d = sat_inc(aw_stalls_q, m_axi_awvalid & ~m_axi_awready);
        w_stalls_d  = sat_inc(w_stalls_q, m_axi_wvalid & ~m_axi_wready);
        b_resps_d   = sat_inc(b_resps_q, b_hs);
        b_errors_d  = sat_inc(b_errors_q, b_hs & (m_axi_bresp != 2'b00));

        // Simultaneous AW and B cancel, so neither boundary check applies.
        if (aw_hs && !b_hs) begin
          if (outstanding_q == '1) proto_err_d = 1'b1;
          else                     outstanding_d = outstanding_q + OUTS_WIDTH'(1);
        end else if (b_hs && !aw_hs) begin
          if (outstanding_q == '0) proto_err_d = 1'b1;
          else                     outstanding_d = outstanding_q - OUTS_WIDTH'(1);
        end

        if (outstanding_d > max_outstanding_q) max_outstanding_d = outstanding_d;
        if (w_lasts_d > aw_bursts_d)           proto_err_d       = 1'b1;

        if (state_q == StRun) begin
          if (wr_busy)          seen_busy_d = 1'b1;
          else if (seen_busy_q) state_d     = StDrain;
        end else if ((outstanding_q == '0) && !aw_hs) begin
          state_d = StDone;
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      seen_busy_q       <= 1'b0;
      cycles_q          <= '0;
      aw_bursts_q       <= '0;
      w_beats_q         <= '0;
      w_lasts_q         <= '0;
      aw_stalls_q       <= '0;
      w_stalls_q        <= '0;
      b_resps_q         <= '0;
      b_errors_q        <= '0;
      outstanding_q     <= '0;
      max_outstanding_q <= '0;
      proto_err_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      seen_busy_q       <= seen_busy_d;
      cycles_q          <= cycles_d;
      aw_bursts_q       <= aw_bursts_d;
      w_beats_q         <= w_beats_d;
      w_lasts_q         <= w_lasts_d;
      aw_stalls_q       <= aw_stalls_d;
      w_stalls_q        <= w_stalls_d;
      b_resps_q         <= b_resps_d;
      b_errors_q        <= b_errors_d;
      outstanding_q     <= outstanding_d;
      max_outstanding_q <= max_outstanding_d;
      proto_err_q       <= proto_err_d;
    end
  end

  assign active          = (state_q == StRun) || (state_q == StDrain);
  assign done            = (state_q == StDone);
  assign cycles          = cycles_q;
  assign aw_bursts       = aw_bursts_q;
  assign w_beats         = w_beats_q;
  assign w_lasts         = w_lasts_q;
  assign aw_stalls       = aw_stalls_q;
  assign w_stalls        = w_stalls_q;
  assign b_resps         = b_resps_q;
  assign b_errors        = b_errors_q;
  assign outstanding     = outstanding_q;
  assign max_outstanding = max_outstanding_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_axi_perf_wr_mon.sv
// Bench for axi_perf_wr_mon: directed scenario table, hand-written corner sequences and a
// randomized run, all checked each cycle against an event-counting reference model.
module tb_axi_perf_wr_mon;

  localparam int CW   = 8;
  localparam int OW   = 3;
  localparam int CMAX = 255;
  localparam int OMAX = 7;

  logic clk = 1'b0;
  logic rst, start, wr_busy;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [1:0] bresp;
  logic active, done, proto_err;
  logic [CW-1:0] cycles, aw_bursts, w_beats, w_lasts, aw_stalls, w_stalls, b_resps, b_errors;
  logic [OW-1:0] outstanding, max_outstanding;

  axi_perf_wr_mon #(
    .AXI_ID_WIDTH(4),
    .CNT_WIDTH   (CW),
    .OUTS_WIDTH  (OW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .wr_busy        (wr_busy),
    .m_axi_awvalid  (awvalid),
    .m_axi_awready  (awready),
    .m_axi_wvalid   (wvalid),
    .m_axi_wready   (wready),
    .m_axi_wlast    (wlast),
    .m_axi_bvalid   (bvalid),
    .m_axi_bready   (bready),
    .m_axi_bresp    (bresp),
    .active         (active),
    .done           (done),
    .cycles         (cycles),
    .aw_bursts      (aw_bursts),
    .w_beats        (w_beats),
    .w_lasts        (w_lasts),
    .aw_stalls      (aw_stalls),
    .w_stalls       (w_stalls),
    .b_resps        (b_resps),
    .b_errors       (b_errors),
    .outstanding    (outstanding),
    .max_outstanding(max_outstanding),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  // Reference model: measurement phase (0 idle, 1 busy, 2 finishing, 3 end pulse) + tallies.
  int m_ph;
  bit m_seen, m_err;
  int m_cyc, m_awb, m_wb, m_wl, m_aws, m_ws, m_br, m_be, m_out, m_max;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_seen = 0; m_err = 0;
    m_cyc = 0; m_awb = 0; m_wb = 0; m_wl = 0; m_aws = 0; m_ws = 0; m_br = 0; m_be = 0;
    m_out = 0; m_max = 0;
  endtask

  task automatic model_step();
    bit aw, b;
    int out_before;
    if (rst) begin
      model_clear();
      m_ph = 0;
      return;
    end
    aw = awvalid && awready;
    b  = bvalid && bready;
    case (m_ph)
      0: if (start) begin model_clear(); m_ph = 1; end
      1, 2: begin
        out_before = m_out;
        m_cyc = sat(m_cyc);
        if (aw) m_awb = sat(m_awb);
        if (wvalid && wready) m_wb = sat(m_wb);
        if (wvalid && wready && wlast) m_wl = sat(m_wl);
        if (awvalid && !awready) m_aws = sat(m_aws);
        if (wvalid && !wready) m_ws = sat(m_ws);
        if (b) m_br = sat(m_br);
        if (b && bresp != 2'b00) m_be = sat(m_be);
        if (aw && !b) begin
          if (m_out == OMAX) m_err = 1; else m_out++;
        end else if (b && !aw) begin
          if (m_out == 0) m_err = 1; else m_out--;
        end
        if (m_out > m_max) m_max = m_out;
        if (m_wl > m_awb) m_err = 1;
        if (m_ph == 1) begin
          if (!wr_busy && m_seen) m_ph = 2;
          if (wr_busy) m_seen = 1;
        end else if (out_before == 0 && !aw) begin
          m_ph = 3;
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("active", int'(active), int'(m_ph == 1 || m_ph == 2));
    chk("done", int'(done), int'(m_ph == 3));
    chk("cycles", int'(cycles), m_cyc);
    chk("aw_bursts", int'(aw_bursts), m_awb);
    chk("w_beats", int'(w_beats), m_wb);
    chk("w_lasts", int'(w_lasts), m_wl);
    chk("aw_stalls", int'(aw_stalls), m_aws);
    chk("w_stalls", int'(w_stalls), m_ws);
    chk("b_resps", int'(b_resps), m_br);
    chk("b_errors", int'(b_errors), m_be);
    chk("outstanding", int'(outstanding), m_out);
    chk("max_outstanding", int'(max_outstanding), m_max);
    chk("proto_err", int'(proto_err), int'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (done) done_cnt++;
  endtask

  task automatic idle_inputs();
    start = 0; awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; bresp = 2'b00;
  endtask

  task automatic arm();
    done_cnt = 0;
    wr_busy = 0;
    start = 1;
    tick();
    start = 0;
    wr_busy = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_wait", int'(done), 1);
    tick();
  endtask

  typedef struct {
    int nb, nbeats, aw_wait, w_gap, bdelay, err_idx;
    int e_aw, e_wb, e_wl, e_aws, e_ws, e_br, e_be, e_max;
  } vec_t;

  vec_t vecs[3];

  task automatic run_vec(input vec_t v);
    arm();
    for (int b = 0; b < v.nb; b++) begin
      awvalid = 1; awready = 0;
      repeat (v.aw_wait) tick();
      awready = 1;
      tick();
      awvalid = 0; awready = 0;
      for (int k = 0; k < v.nbeats; k++) begin
        wvalid = 1;
        wlast  = (k == v.nbeats - 1);
        if (v.w_gap != 0 && (k % 2) == 1) begin
          wready = 0;
          tick();
        end
        wready = 1;
        tick();
      end
      wvalid = 0; wlast = 0; wready = 0;
      repeat (v.bdelay - 1) tick();
      bvalid = 1; bready = 1;
      bresp = (b == v.err_idx) ? 2'b10 : 2'b00;
      tick();
      bvalid = 0; bready = 0; bresp = 2'b00;
    end
    wr_busy = 0;
    wait_done();
    chk("vec_aw_bursts", int'(aw_bursts), v.e_aw);
    chk("vec_w_beats", int'(w_beats), v.e_wb);
    chk("vec_w_lasts", int'(w_lasts), v.e_wl);
    chk("vec_aw_stalls", int'(aw_stalls), v.e_aws);
    chk("vec_w_stalls", int'(w_stalls), v.e_ws);
    chk("vec_b_resps", int'(b_resps), v.e_br);
    chk("vec_b_errors", int'(b_errors), v.e_be);
    chk("vec_max_outs", int'(max_outstanding), v.e_max);
    chk("vec_proto_err", int'(proto_err), 0);
    chk("vec_done_pulses", done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // nb nbeats aw_wait w_gap bdelay err | aw wb wl aws ws br be max
    vecs[0] = '{4, 8, 0, 0, 2, -1, 4, 32, 4, 0, 0, 4, 0, 1};
    vecs[1] = '{2, 4, 3, 1, 2, -1, 2, 8, 2, 6, 4, 2, 0, 1};
    vecs[2] = '{5, 1, 0, 0, 1, 2, 5, 5, 5, 0, 0, 5, 1, 1};

    done_cnt = 0;
    m_ph = 0;
    model_clear();
    idle_inputs();
    wr_busy = 0;
    rst = 1;
    repeat (2) tick();
    rst = 0;

    // Traffic before any start must not be counted.
    awvalid = 1; awready = 1; wvalid = 1; wready = 1; wlast = 1; bvalid = 1; bready = 1;
    repeat (4) tick();
    idle_inputs();
    chk("prestart_aw_bursts", int'(aw_bursts), 0);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      awvalid = 1; wvalid = 1; wready = 1; wlast = 1;
      repeat (3) tick();
      idle_inputs();
    end

    // Responses held back until three bursts are outstanding.
    arm();
    bvalid = 1; bready = 0; awvalid = 1; awready = 1;
    repeat (3) tick();
    awvalid = 0; awready = 0;
    chk("hold_max_outs", int'(max_outstanding), 3);
    wr_busy = 0;
    repeat (4) tick();
    chk("hold_drain_active", int'(active), 1);
    chk("hold_drain_outs", int'(outstanding), 3);
    chk("hold_no_done_yet", done_cnt, 0);
    bready = 1;
    repeat (3) tick();
    bvalid = 0; bready = 0;
    wait_done();
    chk("hold_done_pulses", done_cnt, 1);
    chk("hold_final_max", int'(max_outstanding), 3);

    // Response with nothing outstanding.
    arm();
    tick();
    bvalid = 1; bready = 1;
    tick();
    bvalid = 0; bready = 0;
    chk("orphan_b_err", int'(proto_err), 1);
    chk("orphan_b_outs", int'(outstanding), 0);
    wr_busy = 0;
    wait_done();

    // Same-cycle AW and B, then reset in the middle of a run.
    arm();
    awvalid = 1; awready = 1;
    tick();
    bvalid = 1; bready = 1;
    tick();
    idle_inputs();
    chk("same_cycle_outs", int'(outstanding), 1);
    chk("same_cycle_err", int'(proto_err), 0);
    chk("same_cycle_aw_bursts", int'(aw_bursts), 2);
    tick();
    rst = 1;
    #2;
    m_ph = 0;
    model_clear();
    check_all();
    tick();
    wr_busy = 0;
    rst = 0;
    done_cnt = 0;
    repeat (5) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle_active", int'(active), 0);

    // Counter saturation and outstanding ceiling.
    arm();
    awvalid = 1; awready = 0;
    repeat (300) tick();
    chk("sat_aw_stalls", int'(aw_stalls), CMAX);
    chk("sat_cycles", int'(cycles), CMAX);
    awready = 1;
    repeat (8) tick();
    awvalid = 0; awready = 0;
    chk("ceil_outs", int'(outstanding), OMAX);
    chk("ceil_max", int'(max_outstanding), OMAX);
    chk("ceil_err", int'(proto_err), 1);
    chk("ceil_aw_bursts", int'(aw_bursts), 8);
    wr_busy = 0;
    bvalid = 1; bready = 1;
    repeat (7) tick();
    bvalid = 0; bready = 0;
    wait_done();

    // Randomized traffic, including stray start pulses while armed.
    for (int r = 0; r < 2; r++) begin
      arm();
      for (int c = 0; c < 300; c++) begin
        start   = ($urandom_range(0, 15) == 0);
        awvalid = $urandom_range(0, 1) == 1;
        awready = $urandom_range(0, 1) == 1;
        wvalid  = $urandom_range(0, 1) == 1;
        wready  = $urandom_range(0, 1) == 1;
        wlast   = $urandom_range(0, 3) == 0;
        bvalid  = $urandom_range(0, 1) == 1;
        bready  = $urandom_range(0, 1) == 1;
        bresp   = 2'($urandom_range(0, 3));
        tick();
      end
      idle_inputs();
      wr_busy = 0;
      bvalid = 1; bready = 1;
      wait_done();
      idle_inputs();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_perf_wr_mon.md
AXI_PERF_WR_MON -- requirements
Module: axi_perf_wr_mon

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 4, width of monitored bid (unused except lint).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of all statistic counters.
REQ-003 SHALL have parameter OUTS_WIDTH, default 8, width of the outstanding-burst tracker.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  arm pulse (same pulse driven to the writer).
REQ-007 wr_busy  input  1  writer busy flag.
REQ-008 m_axi_awvalid / m_axi_awready  input  1 each  monitored AW handshake.
REQ-009 m_axi_wvalid / m_axi_wready / m_axi_wlast  input  1 each  monitored W channel.
REQ-010 m_axi_bvalid / m_axi_bready  input  1 each; m_axi_bresp  input  2  monitored B channel.
REQ-011 active  output  1  measurement in progress.
REQ-012 done  output  1  one-cycle pulse at measurement end.
REQ-013 cycles, aw_bursts, w_beats, w_lasts, aw_stalls, w_stalls, b_resps, b_errors  output  CNT_WIDTH each  statistics.
REQ-014 outstanding, max_outstanding  output  OUTS_WIDTH each  current / peak bursts awaiting B.
REQ-015 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-017 IDLE: start=1 -> clear all statistics, outstanding, max_outstanding, proto_err, seen_busy; next state RUN; start outside IDLE ignored.
REQ-018 RUN: seen_busy set when wr_busy=1; wr_busy=0 with seen_busy=1 -> DRAIN.
REQ-019 DRAIN: outstanding=0 and no AW handshake this cycle -> DONE.
REQ-020 DONE: done=1 for exactly that cycle, then IDLE; statistics hold until next start.
REQ-021 active=1 in RUN and DRAIN only.
REQ-022 Counting only in RUN/DRAIN: cycles +1 per cycle; aw_bursts +1 per awvalid&awready; w_beats +1 per wvalid&wready; w_lasts +1 per wvalid&wready&wlast; aw_stalls +1 per awvalid&!awready; w_stalls +1 per wvalid&!wready; b_resps +1 per bvalid&bready; b_errors +1 per B handshake with bresp!=0.
REQ-023 All CNT_WIDTH counters SHALL saturate at all-ones, never wrap.
REQ-024 outstanding: +1 on AW handshake, -1 on B handshake, unchanged when both same cycle.
REQ-025 B handshake with outstanding=0 and no same-cycle AW -> proto_err=1, outstanding stays 0.
REQ-026 AW handshake with outstanding at all-ones -> proto_err=1, outstanding holds.
REQ-027 max_outstanding updated to new outstanding value when greater, same cycle as update.
REQ-028 w_lasts > aw_bursts after any update -> proto_err=1.
REQ-029 Counter values SHALL reflect a handshake on the cycle after it occurs (latency 1).

Reset
REQ-030 rst=1 asynchronously forces IDLE, active=0, done=0, proto_err=0, all counters, outstanding, max_outstanding, seen_busy to 0, including mid-RUN/DRAIN.
REQ-031 After rst release, block SHALL wait in IDLE for start; no counting before start.

Verification
REQ-032 start, 4 bursts x 8 beats, ready always 1, B 2 cycles after wlast -> aw_bursts=4, w_beats=32, w_lasts=4, b_resps=4, stalls=0, proto_err=0, one done pulse.
REQ-033 awready low 3 cycles per burst, wready low every other beat, 2 bursts x 4 beats -> aw_stalls=6, w_stalls matches driven low-ready cycles, w_beats=8.
REQ-034 Hold bready=0 until 3 AWs accepted, then release -> max_outstanding=3, DRAIN persists after wr_busy falls until last B, then done.
REQ-035 bresp=2'b10 on 1 of 5 responses -> b_errors=1, b_resps=5; inject B with outstanding=0 -> proto_err=1, outstanding=0.
REQ-036 Same-cycle AW and B handshakes with outstanding=1 -> outstanding stays 1; assert rst mid-RUN -> all outputs 0, IDLE, no done.
